// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch control unit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/stopwatch_cu_btn_debounce.sv
// One push-button channel: 2-flop synchronizer, optional sampled debouncer
// (STOPWATCH_CU_DEBOUNCE_EN) and a registered rising-edge press pulse.
module btn_debounce #(
  parameter int DB_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;
  logic       press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_i};
  end

`ifdef STOPWATCH_CU_DEBOUNCE_EN
  logic [DB_DEPTH-1:0] shreg_q;
  logic                level_q;
  logic                level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         shreg_q <= '0;
    else if (tick_i) shreg_q <= {shreg_q[DB_DEPTH-2:0], sync_q[1]};
  end

  // Level only moves on a unanimous window; mixed windows keep the old level.
  always_comb begin
    level_d = level_q;
    if (&shreg_q)       level_d = 1'b1;
    else if (~|shreg_q) level_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_d;
  end

  assign level = level_q;
`else
  localparam int unused_depth = DB_DEPTH;
  logic unused_tick;
  assign unused_tick = tick_i;
  assign level       = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level;
      press_q <= level & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: two debounced buttons feeding a Moore STOP/RUN/CLEAR
// FSM. Define STOPWATCH_CU_DEBOUNCE_EN to enable sampled debouncing.
module stopwatch_cu
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 1_000,
  parameter int DB_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  output logic       o_run,
  output logic       o_stop,
  output logic       o_clear,
  output logic [1:0] o_state
);

  logic tick;
  logic press_rs;
  logic press_clr;

`ifdef STOPWATCH_CU_DEBOUNCE_EN
  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_cfg = CLK_HZ + SAMPLE_HZ;
  assign tick = 1'b0;
`endif

  btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_run_stop (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick),
    .btn_i  (btn_run_stop),
    .press_o(press_rs)
  );

  btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_clear (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick),
    .btn_i  (btn_clear),
    .press_o(press_clr)
  );

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  // run_stop has priority over clear in STOP; pulses seen in CLEAR are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (press_rs)       state_d = ST_RUN;
        else if (press_clr) state_d = ST_CLEAR;
      end
      ST_RUN: begin
        if (press_rs) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  always_comb begin
    o_run   = 1'b0;
    o_stop  = 1'b0;
    o_clear = 1'b0;
    case (state_q)
      ST_RUN:   o_run   = 1'b1;
      ST_CLEAR: o_clear = 1'b1;
      default:  o_stop  = 1'b1;
    endcase
  end

  assign o_state = state_q;

endmodule

// File: doc/stopwatch_cu.md
STOPWATCH_CU -- requirements
Module: stopwatch_cu

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter SAMPLE_HZ, default 1_000, debounce sampling rate in Hz; the sample divider is CLK_HZ/SAMPLE_HZ cycles.
REQ-003 Parameter DB_DEPTH, default 8, number of consecutive samples a button must hold to change its debounced level.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_run_stop  input  1  raw, asynchronous push button; each press toggles run and stop.
REQ-007 btn_clear  input  1  raw, asynchronous push button; a press clears the count.
REQ-008 o_run  output  1  high while the FSM is in RUN; drives the datapath run enable.
REQ-009 o_stop  output  1  high while the FSM is in STOP; drives the datapath stop hold.
REQ-010 o_clear  output  1  high while the FSM is in CLEAR; drives the datapath synchronous clear.
REQ-011 o_state  output  2  current state code: STOP=0, RUN=1, CLEAR=2.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 A single shared sample-tick counter SHALL pulse for 1 cycle every CLK_HZ/SAMPLE_HZ cycles and wrap to 0.
REQ-014 On each sample tick, the synchronized button SHALL shift into a DB_DEPTH-bit shift register.
REQ-015 Debounced level SHALL go to 1 when all DB_DEPTH bits are 1, go to 0 when all bits are 0, and otherwise hold.
REQ-016 A rising edge of the debounced level SHALL produce a 1-cycle press pulse; a falling edge produces nothing.
REQ-017 The FSM SHALL be Moore: outputs are decoded only from the state register, and exactly one of o_run/o_stop/o_clear is high in every cycle.
REQ-018 STOP transitions: run_stop pulse -> RUN; else clear pulse -> CLEAR; else stay in STOP.
REQ-019 RUN transitions: run_stop pulse -> STOP; a clear pulse is ignored (stay in RUN).
REQ-020 CLEAR SHALL return to STOP unconditionally after exactly 1 cycle; pulses arriving during CLEAR are discarded.
REQ-021 If run_stop and clear pulse in the same cycle in STOP, run_stop SHALL win.
REQ-022 A held button SHALL yield exactly one pulse per press, regardless of hold duration.
REQ-023 Unused state code 3 SHALL transition to STOP on the next clock.

Reset
REQ-024 Reset SHALL put the FSM in STOP: o_stop=1, o_run=0, o_clear=0, o_state=0.
REQ-025 Reset SHALL zero the synchronizers, shift registers, debounced levels, edge registers and sample counter.
REQ-026 A button held through reset release SHALL produce one pulse once it is debounced.

Configuration
REQ-027 Macro STOPWATCH_CU_DEBOUNCE_EN, when defined, SHALL compile in the sample counter and shift-register debouncing described in REQ-013 to REQ-015.
REQ-028 When the macro is undefined, the debounced level SHALL be the synchronizer output directly.
REQ-029 Without the macro, a clean input rise SHALL produce a pulse in the 3rd cycle after the rise, and SAMPLE_HZ and DB_DEPTH are unused.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state encodings (STOP, RUN, CLEAR) and the 2-bit state type.
REQ-031 Sub-module btn_debounce SHALL implement the synchronizer, debouncer and edge detector for one button.
REQ-032 stopwatch_cu SHALL instantiate btn_debounce twice, with the sample tick supplied from the parent.

Verification (CLK_HZ=10_000, SAMPLE_HZ=1_000, DB_DEPTH=8, i.e. a tick every 10 cycles, macro defined unless noted)
REQ-033 Reset, then idle for 200 cycles -> o_stop=1 and o_state=0 throughout.
REQ-034 Hold btn_run_stop high for 150 cycles -> one press pulse within 8 ticks plus 4 cycles, then o_run=1 and o_state=1; it stays RUN after release.
REQ-035 Toggle btn_run_stop every 3 cycles for 100 cycles (bounce) -> no pulse and no state change.
REQ-036 In STOP, press btn_clear -> o_clear=1 for exactly 1 cycle, then o_stop=1; in RUN, press btn_clear -> state stays RUN.
REQ-037 Force both pulses in the same cycle in STOP -> next state RUN; assert rst mid-press -> immediate STOP and all outputs at reset values.
REQ-038 With the macro undefined, a 1-cycle-wide input rise -> pulse in the 3rd cycle after the rise and a state change on the following edge.
